// File: rtl/pgr_uart_cmd_pkg.sv
// Shared constants for the UART register command controller: opcodes,
// response bytes and FSM state encodings.
package pgr_uart_cmd_pkg;
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    BUS  = 3'd3,
    RESP = 3'd4,
    ERR  = 3'd5
  } state_t;
endpackage

// File: rtl/pgr_uart_cmd_ctrl_32bit.sv
// UART command frame decoder driving a 32-bit register bus.
// Frames: 'W' a1 a0 d3 d2 d1 d0 -> 'K'; 'R' a1 a0 -> d3 d2 d1 d0; bad frame -> 'E'.
module pgr_uart_cmd_ctrl_32bit
  import pgr_uart_cmd_pkg::*;
#(
  parameter logic [23:0] BYTE_TIMEOUT = 24'd5_000_000,
  parameter logic [15:0] BUS_TIMEOUT  = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_fifo_rd_data,
  input  logic        rx_fifo_rd_data_valid,
  output logic        rx_fifo_rd_data_req,
  input  logic        rx_chk_err,
  output logic [7:0]  tx_fifo_wr_data,
  input  logic        tx_fifo_wr_data_valid,
  output logic        tx_fifo_wr_data_req,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic        busy
);

  state_t      r_state, w_next;
  logic        r_is_wr;
  logic [2:0]  r_cnt;
  logic [31:0] r_shift;
  logic [15:0] r_addr;
  logic [23:0] r_gap;
  logic [15:0] r_bus;
  logic        r_wr, r_rd;
  logic        w_pop, w_push, w_gap_to, w_bus_to, w_op_ok;

  assign w_gap_to = (r_gap == BYTE_TIMEOUT - 24'd1);
  assign w_bus_to = (r_bus == BUS_TIMEOUT - 16'd1);
  assign w_op_ok  = (rx_fifo_rd_data == OP_WR) || (rx_fifo_rd_data == OP_RD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_push = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop = rx_fifo_rd_data_valid && !rst;
        if (rx_chk_err)  w_next = ERR;
        else if (w_pop)  w_next = w_op_ok ? ADDR : ERR;
      end
      ADDR: begin
        w_pop = rx_fifo_rd_data_valid && !rst;
        if (rx_chk_err)    w_next = ERR;
        else if (w_pop)    begin
          if (r_cnt == 3'd1) w_next = r_is_wr ? DATA : BUS;
        end
        else if (w_gap_to) w_next = IDLE;
      end
      DATA: begin
        w_pop = rx_fifo_rd_data_valid && !rst;
        if (rx_chk_err)    w_next = ERR;
        else if (w_pop)    begin
          if (r_cnt == 3'd3) w_next = BUS;
        end
        else if (w_gap_to) w_next = IDLE;
      end
      BUS: begin
        if (reg_ack)       w_next = RESP;
        else if (w_bus_to) w_next = ERR;
      end
      RESP: begin
        w_push = tx_fifo_wr_data_valid && !rst;
        if (w_push && r_cnt == 3'd1) w_next = IDLE;
      end
      ERR: begin
        w_push = tx_fifo_wr_data_valid && !rst;
        if (w_push) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // r_cnt counts collected bytes in ADDR/DATA and bytes still to send in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_wr <= 1'b0;
      r_cnt   <= 3'd0;
      r_shift <= 32'd0;
      r_addr  <= 16'd0;
      r_gap   <= 24'd0;
      r_bus   <= 16'd0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= 3'd0;
          r_gap <= 24'd0;
          if (w_pop && !rx_chk_err) r_is_wr <= (rx_fifo_rd_data == OP_WR);
        end
        ADDR: begin
          if (w_pop && !rx_chk_err) begin
            r_addr <= {r_addr[7:0], rx_fifo_rd_data};
            r_cnt  <= (r_cnt == 3'd1) ? 3'd0 : r_cnt + 3'd1;
            r_gap  <= 24'd0;
          end else begin
            r_gap  <= r_gap + 24'd1;
          end
        end
        DATA: begin
          if (w_pop && !rx_chk_err) begin
            r_shift <= {r_shift[23:0], rx_fifo_rd_data};
            r_cnt   <= r_cnt + 3'd1;
            r_gap   <= 24'd0;
          end else begin
            r_gap   <= r_gap + 24'd1;
          end
        end
        BUS: begin
          if (reg_ack) begin
            r_wr <= 1'b0;
            r_rd <= 1'b0;
            if (r_rd) begin
              r_shift <= reg_rdata;
              r_cnt   <= 3'd4;
            end else begin
              r_shift <= {RSP_OK, 24'd0};
              r_cnt   <= 3'd1;
            end
          end else if (w_bus_to) begin
            r_wr <= 1'b0;
            r_rd <= 1'b0;
          end else begin
            r_bus <= r_bus + 16'd1;
          end
        end
        RESP: begin
          if (w_push) begin
            r_shift <= {r_shift[23:0], 8'h00};
            r_cnt   <= r_cnt - 3'd1;
          end
        end
        default: ;
      endcase
      if (w_next == BUS && r_state != BUS) begin
        r_wr  <= r_is_wr;
        r_rd  <= !r_is_wr;
        r_bus <= 16'd0;
      end
      // Every error path converges here so the 'E' byte is loaded exactly once.
      if (w_next == ERR && r_state != ERR) r_shift <= {RSP_ERR, 24'd0};
    end
  end

  assign rx_fifo_rd_data_req = w_pop;
  assign tx_fifo_wr_data_req = w_push;
  assign tx_fifo_wr_data     = r_shift[31:24];
  assign reg_wdata           = r_shift;
  assign reg_addr            = r_addr;
  assign reg_wr              = r_wr;
  assign reg_rd              = r_rd;
  assign busy                = (r_state != IDLE);

endmodule

// File: tb/tb_pgr_uart_cmd_ctrl_32bit.sv
// Scoreboard bench: frames go into an rx FIFO model, expected tx bytes and
// bus transactions are queued up front and popped as the DUT produces them.
module tb_pgr_uart_cmd_ctrl_32bit;
  localparam logic [23:0] BT = 24'd40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_fifo_rd_data = 8'h00;
  logic        rx_fifo_rd_data_valid = 1'b0;
  logic        rx_fifo_rd_data_req;
  logic        rx_chk_err = 1'b0;
  logic [7:0]  tx_fifo_wr_data;
  logic        tx_fifo_wr_data_valid = 1'b1;
  logic        tx_fifo_wr_data_req;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr, reg_rd;
  logic [31:0] reg_rdata = 32'd0;
  logic        reg_ack = 1'b0;
  logic        busy;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
  } bus_t;

  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];
  bus_t       exp_bus[$];
  int n_chk = 0, n_fail = 0;
  int tx_cnt = 0, bus_done = 0, rd_hi = 0, wr_hi = 0;
  int bus_age = 0, ack_dly = 2, stall_at = 0, stall_left = 0;

  pgr_uart_cmd_ctrl_32bit #(.BYTE_TIMEOUT(BT), .BUS_TIMEOUT(16'd1024)) dut (
    .clk(clk), .rst(rst),
    .rx_fifo_rd_data(rx_fifo_rd_data), .rx_fifo_rd_data_valid(rx_fifo_rd_data_valid),
    .rx_fifo_rd_data_req(rx_fifo_rd_data_req), .rx_chk_err(rx_chk_err),
    .tx_fifo_wr_data(tx_fifo_wr_data), .tx_fifo_wr_data_valid(tx_fifo_wr_data_valid),
    .tx_fifo_wr_data_req(tx_fifo_wr_data_req),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // rx FIFO model: pop on the request seen at the edge, present the new head after it.
  always @(posedge clk) begin
    if (rx_fifo_rd_data_req && rx_q.size() > 0) void'(rx_q.pop_front());
    #1;
    rx_fifo_rd_data_valid = (rx_q.size() > 0);
    rx_fifo_rd_data       = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // tx FIFO model with an optional 10-cycle backpressure window after byte stall_at.
  always @(posedge clk) begin
    if (tx_fifo_wr_data_req) begin
      check("tx_gate", {31'd0, tx_fifo_wr_data_valid}, 32'd1);
      check("tx_has_exp", {31'd0, exp_tx.size() > 0}, 32'd1);
      if (exp_tx.size() > 0) check("tx_byte", {24'd0, tx_fifo_wr_data}, {24'd0, exp_tx.pop_front()});
      tx_cnt++;
      if (tx_cnt == stall_at) stall_left = 10;
    end
    #1;
    if (stall_left == 1 && exp_tx.size() > 0)
      check("tx_hold", {24'd0, tx_fifo_wr_data}, {24'd0, exp_tx[0]});
    tx_fifo_wr_data_valid = (stall_left == 0);
    if (stall_left > 0) stall_left--;
  end

  // Register bus model: ack ack_dly cycles after the request rises; -1 never acks.
  always @(posedge clk) begin
    if (reg_rd) rd_hi++;
    if (reg_wr) wr_hi++;
    if ((reg_wr || reg_rd) && reg_ack) begin
      bus_done++;
      check("bus_has_exp", {31'd0, exp_bus.size() > 0}, 32'd1);
      if (exp_bus.size() > 0) begin
        bus_t e;
        e = exp_bus.pop_front();
        check("bus_wr", {31'd0, reg_wr}, {31'd0, e.wr});
        check("bus_rd", {31'd0, reg_rd}, {31'd0, !e.wr});
        check("bus_addr", {16'd0, reg_addr}, {16'd0, e.addr});
        if (e.wr) check("bus_wdata", reg_wdata, e.wdata);
      end
    end
    #1;
    if (reg_wr || reg_rd) begin
      bus_age++;
      reg_ack = (ack_dly >= 0) && (bus_age == ack_dly);
    end else begin
      bus_age = 0;
      reg_ack = 1'b0;
    end
  end

  task automatic send(input logic [7:0] op, input logic [15:0] addr,
                      input logic [31:0] data, input int nbytes);
    logic [55:0] f;
    f = {op, addr, data};
    for (int i = 0; i < nbytes; i++) rx_q.push_back(f[55-8*i -: 8]);
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (!(rx_q.size() == 0 && !busy && exp_tx.size() == 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, n < max}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, t0, r0, w0, n;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {16'd0, reg_addr}, 32'd0);
    check("rst_wdata", reg_wdata, 32'd0);
    check("rst_txdata", {24'd0, tx_fifo_wr_data}, 32'd0);
    check("rst_bus", {30'd0, reg_wr, reg_rd}, 32'd0);
    check("rst_req", {30'd0, rx_fifo_rd_data_req, tx_fifo_wr_data_req}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // write frame
    ack_dly = 2;
    exp_bus.push_back('{1'b1, 16'h0010, 32'hDEADBEEF});
    exp_tx.push_back(8'h4B);
    send(8'h57, 16'h0010, 32'hDEADBEEF, 7);
    wait_idle(200, "wr_done");

    // read frame acked after 3 cycles; a parity pulse during BUS is ignored
    ack_dly = 3;
    reg_rdata = 32'h12345678;
    exp_bus.push_back('{1'b0, 16'h0020, 32'h0});
    exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
    send(8'h52, 16'h0020, 32'h0, 3);
    n = 0;
    while (!reg_rd && n < 50) begin @(negedge clk); n++; end
    check("rd_seen", {31'd0, reg_rd}, 32'd1);
    rx_chk_err = 1'b1;
    @(negedge clk);
    rx_chk_err = 1'b0;
    wait_idle(200, "rd_done");

    // bad opcode followed directly by a good frame
    ack_dly = 2;
    exp_tx.push_back(8'h45);
    exp_bus.push_back('{1'b1, 16'h0030, 32'h01020304});
    exp_tx.push_back(8'h4B);
    rx_q.push_back(8'h41);
    send(8'h57, 16'h0030, 32'h01020304, 7);
    wait_idle(300, "badop_done");

    // byte-gap timeout aborts silently
    b0 = bus_done; t0 = tx_cnt; w0 = wr_hi;
    send(8'h57, 16'h0000, 32'h0, 2);
    repeat (BT / 2) @(negedge clk);
    check("bto_busy", {31'd0, busy}, 32'd1);
    wait_idle(BT + 20, "bto_done");
    check("bto_nobus", bus_done, b0);
    check("bto_notx", tx_cnt, t0);
    check("bto_nowr", wr_hi, w0);

    // parity error while collecting the address
    b0 = bus_done; r0 = rd_hi;
    exp_tx.push_back(8'h45);
    rx_q.push_back(8'h52);
    repeat (4) @(negedge clk);
    rx_chk_err = 1'b1;
    @(negedge clk);
    rx_chk_err = 1'b0;
    wait_idle(100, "chk_done");
    check("chk_nobus", bus_done, b0);
    check("chk_nord", rd_hi, r0);

    // bus timeout on a read that is never acked
    ack_dly = -1;
    r0 = rd_hi;
    exp_tx.push_back(8'h45);
    send(8'h52, 16'h0040, 32'h0, 3);
    wait_idle(1300, "busto_done");
    check("busto_rd_cycles", rd_hi - r0, 1024);
    check("busto_rd_low", {31'd0, reg_rd}, 32'd0);

    // tx backpressure for 10 cycles before the second read byte
    ack_dly = 1;
    reg_rdata = 32'hA1B2C3D4;
    t0 = tx_cnt;
    stall_at = tx_cnt + 1;
    exp_bus.push_back('{1'b0, 16'h0050, 32'h0});
    exp_tx.push_back(8'hA1); exp_tx.push_back(8'hB2);
    exp_tx.push_back(8'hC3); exp_tx.push_back(8'hD4);
    send(8'h52, 16'h0050, 32'h0, 3);
    wait_idle(300, "stall_done");
    check("stall_cnt", tx_cnt - t0, 4);

    // reset in the middle of a bus cycle
    ack_dly = -1;
    t0 = tx_cnt;
    send(8'h57, 16'h0060, 32'h11223344, 7);
    n = 0;
    while (!reg_wr && n < 50) begin @(negedge clk); n++; end
    check("mrst_wr_seen", {31'd0, reg_wr}, 32'd1);
    rst = 1'b1;
    #1;
    check("mrst_wr_drop", {30'd0, reg_wr, reg_rd}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("mrst_notx", tx_cnt, t0);
    check("mrst_idle", {30'd0, busy, reg_wr}, 32'd0);

    check("end_exp_tx", exp_tx.size(), 0);
    check("end_exp_bus", exp_bus.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
